// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
// Holds the state encoding, failure codes and default timing values.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SHIFT,
    ST_ACK,
    ST_RELEASE
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_START_TO = 2'b01;
  localparam logic [1:0] ERR_NO_ACK   = 2'b10;
  localparam logic [1:0] ERR_XFER_TO  = 2'b11;

  localparam int unsigned DEF_CLK_HZ       = 50_000_000;
  localparam int unsigned DEF_INHIBIT_CYC  = 5000;
  localparam int unsigned DEF_START_TO_CYC = 750_000;
  localparam int unsigned DEF_XFER_TO_CYC  = 100_000;

  localparam int TMR_W = 20;
  localparam int BIT_W = 4;

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one open-collector PS/2 line, plus falling-edge
// detect on the synchronized level. Flops reset to 1 (idle line level).
module ps2_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic fall
);

  logic meta;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign fall = prev & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, clocked
// shift of data/parity/stop under device clock, ACK check, then line release.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ       = DEF_CLK_HZ,
  parameter int unsigned INHIBIT_CYC  = DEF_INHIBIT_CYC,
  parameter int unsigned START_TO_CYC = DEF_START_TO_CYC,
  parameter int unsigned XFER_TO_CYC  = DEF_XFER_TO_CYC
) (
  input  logic       CLOCK_50,
  input  logic       KEY0,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  if (CLK_HZ == 0) begin : g_clk_hz_check
    $error("CLK_HZ must be nonzero");
  end

  logic clk_s, clk_fall, dat_s, dat_fall_unused;

  ps2_sync_edge u_clk_sync (
    .clk(CLOCK_50), .rst_n(KEY0), .din(ps2_clk_in), .sync(clk_s), .fall(clk_fall)
  );

  ps2_sync_edge u_dat_sync (
    .clk(CLOCK_50), .rst_n(KEY0), .din(ps2_dat_in), .sync(dat_s), .fall(dat_fall_unused)
  );

  state_t             state, state_nx;
  logic [TMR_W-1:0]   tmr, tmr_nx, tmr_dec;
  logic [BIT_W-1:0]   bit_cnt, bit_cnt_nx;
  logic [8:0]         shreg, shreg_nx;
  logic               drive, drive_nx;
  logic               done_nx, err_nx;
  logic [1:0]         err_code_nx;
  logic               tmr_zero, accept;

  assign tmr_zero  = (tmr == '0);
  assign tmr_dec   = tmr_zero ? tmr : tmr - 1'b1;
  assign cmd_ready = (state == ST_IDLE) && clk_s && dat_s && !done && !err;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != ST_IDLE);

  always_comb begin
    state_nx    = state;
    tmr_nx      = tmr_dec;
    bit_cnt_nx  = bit_cnt;
    shreg_nx    = shreg;
    drive_nx    = drive;
    done_nx     = 1'b0;
    err_nx      = 1'b0;
    err_code_nx = err_code;
    ps2_clk_oe  = 1'b0;
    ps2_dat_oe  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nx    = ST_INHIBIT;
          tmr_nx      = TMR_W'(INHIBIT_CYC - 1);
          bit_cnt_nx  = '0;
          shreg_nx    = {~^cmd_data, cmd_data};
          drive_nx    = 1'b0;
          err_code_nx = ERR_NONE;
        end
      end
      ST_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        ps2_dat_oe = tmr_zero;
        if (tmr_zero) begin
          state_nx = ST_REQ;
          tmr_nx   = TMR_W'(START_TO_CYC - 1);
        end
      end
      ST_REQ: begin
        ps2_dat_oe = 1'b1;
        // Timeout wins over a falling edge arriving in the same cycle.
        if (tmr_zero) begin
          state_nx    = ST_RELEASE;
          err_nx      = 1'b1;
          err_code_nx = ERR_START_TO;
        end else if (clk_fall) begin
          state_nx   = ST_SHIFT;
          tmr_nx     = TMR_W'(XFER_TO_CYC - 1);
          bit_cnt_nx = 4'd1;
          drive_nx   = ~shreg[0];
          shreg_nx   = {1'b1, shreg[8:1]};
        end
      end
      ST_SHIFT: begin
        ps2_dat_oe = drive;
        if (tmr_zero) begin
          state_nx    = ST_RELEASE;
          err_nx      = 1'b1;
          err_code_nx = ERR_XFER_TO;
        end else if (clk_fall) begin
          bit_cnt_nx = bit_cnt + 1'b1;
          if (bit_cnt == 4'd9) begin
            drive_nx = 1'b0;
            state_nx = ST_ACK;
          end else begin
            drive_nx = ~shreg[0];
            shreg_nx = {1'b1, shreg[8:1]};
          end
        end
      end
      ST_ACK: begin
        if (tmr_zero) begin
          state_nx    = ST_RELEASE;
          err_nx      = 1'b1;
          err_code_nx = ERR_XFER_TO;
        end else if (clk_fall) begin
          state_nx   = ST_RELEASE;
          bit_cnt_nx = 4'd11;
          if (!dat_s) begin
            done_nx = 1'b1;
          end else begin
            err_nx      = 1'b1;
            err_code_nx = ERR_NO_ACK;
          end
        end
      end
      ST_RELEASE: begin
        if (clk_s && dat_s) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      state    <= ST_IDLE;
      tmr      <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      drive    <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      state    <= state_nx;
      tmr      <= tmr_nx;
      bit_cnt  <= bit_cnt_nx;
      shreg    <= shreg_nx;
      drive    <= drive_nx;
      done     <= done_nx;
      err      <= err_nx;
      err_code <= err_code_nx;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a wired-AND PS/2 line and a simple
// device model that clocks frames and optionally ACKs.
module tb_ps2_host_tx;

  localparam int H   = 10;
  localparam int INH = 5000;
  localparam int STO = 2000;
  localparam int XTO = 3000;

  logic       clk = 1'b0;
  logic       KEY0 = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       cmd_ready, ps2_clk_oe, ps2_dat_oe, busy, done, err;
  logic [1:0] err_code;
  logic       ps2_clk_in, ps2_dat_in;

  int checks = 0, errors = 0;
  int done_tot = 0, err_tot = 0, ready_tot = 0;

  always #10 clk = ~clk;

  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  always @(negedge clk) begin
    if (done === 1'b1) done_tot++;
    if (err === 1'b1) err_tot++;
    if (cmd_ready === 1'b1) ready_tot++;
  end

  ps2_host_tx #(
    .INHIBIT_CYC(INH), .START_TO_CYC(STO), .XFER_TO_CYC(XTO)
  ) dut (
    .CLOCK_50(clk), .KEY0(KEY0), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe), .busy(busy),
    .done(done), .err(err), .err_code(err_code)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_data  = d;
    check("ready_before_accept", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int b = 0;
    while (busy !== 1'b0 && b < 1000) begin @(negedge clk); b++; end
    check(tag, 32'(busy), 32'd0);
  endtask

  // Counts inhibit length, then clocks n_edges device clocks, sampling the
  // host data line late in each low phase; optionally pulls data low for ACK.
  task automatic device_xfer(input int n_edges, input logic ack_low,
                             output logic [10:0] frame, output int inh_cnt);
    int b = 0;
    frame = '0;
    inh_cnt = 0;
    while (ps2_clk_oe !== 1'b1 && b < 100) begin @(negedge clk); b++; end
    while (ps2_clk_oe === 1'b1 && inh_cnt < 20000) begin @(negedge clk); inh_cnt++; end
    repeat (H) @(negedge clk);
    frame[0] = ps2_dat_in;
    for (int k = 1; k <= n_edges; k++) begin
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      if (k <= 10) frame[k] = ps2_dat_in;
      dev_clk = 1'b1;
      if (k == 10 && ack_low) dev_dat = 1'b0;
      repeat (H) @(negedge clk);
    end
    dev_dat = 1'b1;
  endtask

  initial begin
    logic [10:0] frame;
    int inh, d0, e0, r0, n, b;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done_err", 32'({done, err}), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    KEY0 = 1'b1;
    repeat (3) @(negedge clk);

    // 0xED with ACK
    d0 = done_tot; e0 = err_tot;
    send_cmd(8'hED);
    device_xfer(11, 1'b1, frame, inh);
    check("ed_frame", 32'(frame), 32'({1'b1, 1'b1, 8'hED, 1'b0}));
    check("ed_inhibit_len", 32'(inh), 32'd5000);
    check("ed_done_pulses", 32'(done_tot - d0), 32'd1);
    check("ed_err_pulses", 32'(err_tot - e0), 32'd0);
    wait_idle("ed_back_idle");
    check("ed_err_code", 32'(err_code), 32'd0);

    // 0xF4 with ACK
    d0 = done_tot;
    send_cmd(8'hF4);
    device_xfer(11, 1'b1, frame, inh);
    check("f4_frame", 32'(frame), 32'({1'b1, 1'b0, 8'hF4, 1'b0}));
    check("f4_inhibit_len", 32'(inh), 32'd5000);
    check("f4_done_pulses", 32'(done_tot - d0), 32'd1);
    wait_idle("f4_back_idle");

    // Silent device: start timeout
    send_cmd(8'hF4);
    b = 0;
    while (ps2_clk_oe === 1'b1 && b < 6000) begin @(negedge clk); b++; end
    check("sto_in_req", 32'({ps2_clk_oe, ps2_dat_oe}), 32'b01);
    n = 0;
    while (err !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    check("sto_latency", 32'(n), 32'd2000);
    check("sto_err_code", 32'(err_code), 32'b01);
    check("sto_oe_released", 32'({ps2_clk_oe, ps2_dat_oe}), 32'b00);
    wait_idle("sto_back_idle");

    // No ACK: data left high at edge 11
    d0 = done_tot; e0 = err_tot;
    send_cmd(8'hED);
    device_xfer(11, 1'b0, frame, inh);
    check("nak_frame", 32'(frame), 32'({1'b1, 1'b1, 8'hED, 1'b0}));
    check("nak_err_pulses", 32'(err_tot - e0), 32'd1);
    check("nak_done_pulses", 32'(done_tot - d0), 32'd0);
    check("nak_err_code", 32'(err_code), 32'b10);
    wait_idle("nak_back_idle");

    // Reset in the middle of bit 4 (d3 of 0xF4 is 0, so data is driven)
    send_cmd(8'hF4);
    b = 0;
    while (ps2_clk_oe === 1'b1 && b < 6000) begin @(negedge clk); b++; end
    repeat (H) @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      if (k < 4) begin
        dev_clk = 1'b1;
        repeat (H) @(negedge clk);
      end
    end
    check("mid_dat_oe_bit4", 32'(ps2_dat_oe), 32'd1);
    #2 KEY0 = 1'b0;
    #1;
    check("arst_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'b00);
    check("arst_busy", 32'(busy), 32'd0);
    dev_clk = 1'b1;
    @(negedge clk);
    KEY0 = 1'b1;
    repeat (3) @(negedge clk);
    d0 = done_tot;
    send_cmd(8'hF4);
    device_xfer(11, 1'b1, frame, inh);
    check("post_rst_frame", 32'(frame), 32'({1'b1, 1'b0, 8'hF4, 1'b0}));
    check("post_rst_done", 32'(done_tot - d0), 32'd1);
    wait_idle("post_rst_idle");

    // cmd_valid held across two commands
    cmd_valid = 1'b1;
    cmd_data  = 8'hED;
    @(negedge clk);
    check("hold_first_accepted", 32'(busy), 32'd1);
    cmd_data = 8'hF4;
    r0 = ready_tot;
    device_xfer(11, 1'b1, frame, inh);
    check("hold_ready_low_first", 32'(ready_tot - r0), 32'd0);
    check("hold_first_frame", 32'(frame), 32'({1'b1, 1'b1, 8'hED, 1'b0}));
    b = 0;
    while (ps2_clk_oe !== 1'b1 && b < 100) begin @(negedge clk); b++; end
    check("hold_second_accepted", 32'(ps2_clk_oe), 32'd1);
    cmd_valid = 1'b0;
    device_xfer(11, 1'b1, frame, inh);
    check("hold_second_frame", 32'(frame), 32'({1'b1, 1'b0, 8'hF4, 1'b0}));
    wait_idle("hold_back_idle");
    check("final_ready", 32'(cmd_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50_000_000, meaning system clock frequency.
REQ-002 The block SHALL have parameter INHIBIT_CYC, default 5000, meaning PS2 clock-low hold (100 us).
REQ-003 The block SHALL have parameter START_TO_CYC, default 750_000, meaning wait for the first device clock (15 ms).
REQ-004 The block SHALL have parameter XFER_TO_CYC, default 100_000, meaning first device clock to ACK (2 ms).
REQ-005 The block SHALL have port CLOCK_50, input, 1 bit, meaning the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port KEY0, input, 1 bit, meaning reset, asynchronous and active-low.
REQ-007 The block SHALL have port cmd_valid, input, 1 bit, meaning a command byte is offered.
REQ-008 The block SHALL have port cmd_data, input, 8 bits, meaning the command byte (e.g. 0xED set-LEDs, 0xF4 enable).
REQ-009 The block SHALL have port cmd_ready, output, 1 bit, meaning the block accepts a command this cycle.
REQ-010 The block SHALL have port ps2_clk_in, input, 1 bit, meaning the raw PS2_CLK pad level.
REQ-011 The block SHALL have port ps2_dat_in, input, 1 bit, meaning the raw PS2_DAT pad level.
REQ-012 The block SHALL have port ps2_clk_oe, output, 1 bit, meaning drive PS2_CLK low when 1 and release when 0.
REQ-013 The block SHALL have port ps2_dat_oe, output, 1 bit, meaning drive PS2_DAT low when 1 and release when 0.
REQ-014 The block SHALL have port busy, output, 1 bit, meaning a transfer is in progress, so the receiver ignores the line.
REQ-015 The block SHALL have port done, output, 1 bit, meaning a one-cycle pulse when a transfer completes with ACK.
REQ-016 The block SHALL have port err, output, 1 bit, meaning a one-cycle pulse when a transfer fails.
REQ-017 The block SHALL have port err_code, output, 2 bits, meaning the failure cause: 01 start timeout, 10 no ACK, 11 transfer timeout; held until the next accepted command.

Function
REQ-018 The block SHALL pass ps2_clk_in and ps2_dat_in each through a 2-flop synchronizer; a device falling edge is synced clk at 1 in the previous cycle and 0 in the current one.
REQ-019 The block SHALL take a command only when cmd_valid and cmd_ready are both 1; it SHALL latch cmd_data and the odd parity bit (~^cmd_data) in that cycle.
REQ-020 The block SHALL drive cmd_ready = 1 only in IDLE, when both synced lines are high and err/done are not pulsing.
REQ-021 The block SHALL implement states IDLE, INHIBIT, REQ, SHIFT, ACK, RELEASE.
REQ-022 IDLE SHALL go to INHIBIT on command acceptance.
REQ-023 INHIBIT SHALL set clk_oe=1 and dat_oe=0 for INHIBIT_CYC cycles; at the last cycle it SHALL set dat_oe=1 (start bit) and go to REQ.
REQ-024 REQ SHALL set clk_oe=0 and dat_oe=1 and wait for a device falling edge; after START_TO_CYC cycles with no falling edge it SHALL set err with code 01 and go to RELEASE.
REQ-025 In SHIFT, falling edges 1..8 SHALL present data bits d0..d7 (LSB first) with dat_oe = ~bit.
REQ-026 In SHIFT, falling edge 9 SHALL present the parity bit with dat_oe = ~parity.
REQ-027 In SHIFT, falling edge 10 SHALL set dat_oe=0 (stop) and go to ACK.
REQ-028 In ACK, at falling edge 11 the block SHALL sample synced data; 0 SHALL raise done and 1 SHALL raise err with code 10; either way it SHALL go to RELEASE.
REQ-029 The block SHALL count XFER_TO_CYC from the first falling edge; if it expires in SHIFT or ACK, the block SHALL set err with code 11 and go to RELEASE.
REQ-030 RELEASE SHALL hold both oe at 0 until both synced lines are high, then go to IDLE.
REQ-031 The bit counter SHALL be 4 bits, 0..11; it SHALL never wrap, and it SHALL clear on acceptance.
REQ-032 The timeout counter SHALL be 20 bits and saturating.
REQ-033 busy SHALL be 1 in every state except IDLE.
REQ-034 cmd_valid asserted outside IDLE SHALL be ignored; the offered byte is not consumed.
REQ-035 A falling edge in the same cycle a timeout expires SHALL resolve to the timeout.

Reset
REQ-036 On KEY0 low, the block SHALL at once, without a clock, force state IDLE, clk_oe=0, dat_oe=0, busy=0, done=0, err=0, err_code=00, and clear the counters, the shift register and the synchronizers (to 1).
REQ-037 Reset during a transfer SHALL release both lines at once; no partial frame resumes after reset deasserts.

Structure
REQ-038 Shared package ps2_pkg SHALL hold the state enum, the err_code constants and the default timing constants.
REQ-039 Sub-module ps2_sync_edge SHALL hold the 2-flop synchronizer plus falling-edge detect; it SHALL be used once per line, with edge output on the clock line only.

Verification
REQ-040 Send 0xED with the device model ACKing -> frame 0,1,0,1,1,0,1,1,1,parity 1,stop 1; ACK low; done pulses once; err stays 0.
REQ-041 Send 0xF4 -> data bits 0,0,1,0,1,1,1,1, parity 0; clk_oe is high for exactly 5000 cycles before release.
REQ-042 Device gives no clocks -> err with code 01 exactly 750_000 cycles after REQ entry; both oe are 0 after.
REQ-043 Device gives 11 clocks but leaves data high at edge 11 -> err with code 10; done stays 0.
REQ-044 KEY0 low at bit 4 of a transfer -> clk_oe=dat_oe=0 and busy=0 with no clock edge; the next command completes normally.
REQ-045 cmd_valid held high across two commands -> second accepted only after RELEASE sees both lines high; cmd_ready=0 throughout the first.
